mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Shares one memory port, using the core's generic req/gnt/rvalid protocol, among NR_PORTS requesters. Each cycle it picks one requester by round-robin and passes that requester's request through combinationally. It records each granted port index in an in-order ID FIFO and routes each returning rvalid to the port that owns it. It sits between the core-side memory clients (fetch, load/store, PTW) and a single memory port or cache.

## Interface
Parameters:
- NR_PORTS, 3: number of requesters, ≥2.
- ADDRESS_SIZE, 64: address width.
- DATA_WIDTH, 64: data width; byte-enable width is DATA_WIDTH/8.
- MAX_OUTSTANDING, 4: ID FIFO depth, ≥1, power of two.

Ports:
- clk_i  in  1  clock, all state on rising edge.
- rst_i  in  1  synchronous, active-high reset.
- req_i  in  NR_PORTS  per-port request.
- address_i  in  NR_PORTS×ADDRESS_SIZE  per-port address.
- wdata_i  in  NR_PORTS×DATA_WIDTH  per-port write data.
- we_i  in  NR_PORTS  per-port write enable.
- be_i  in  NR_PORTS×DATA_WIDTH/8  per-port byte enable.
- gnt_o  out  NR_PORTS  per-port grant.
- rvalid_o  out  NR_PORTS  per-port read-valid.
- rdata_o  out  DATA_WIDTH  read data, broadcast to all ports.
- req_o, address_o, wdata_o, we_o, be_o  out  (1, ADDRESS_SIZE, DATA_WIDTH, 1, DATA_WIDTH/8)  request fields to memory.
- gnt_i  in  1  memory grant.
- rvalid_i  in  1  memory read-valid.
- rdata_i  in  DATA_WIDTH  memory read data.
- err_o  out  1  sticky protocol error: rvalid_i arrived with the FIFO empty.

## Operation
State:
- rr_q: priority pointer, clog2(NR_PORTS) bits.
- lock_q, sel_q: hold the current selection while a request waits for its grant.
- ID FIFO of MAX_OUTSTANDING entries, each clog2(NR_PORTS) bits, with a count.
- err_q.

Arbitration:
- When lock_q=0, sel is the first asserted req_i searching from rr_q upward, wrapping modulo NR_PORTS.
- When lock_q=1, sel=sel_q.
- req_o = req_i[sel] & !full. The address/wdata/we/be outputs mux from sel.
- gnt_o[sel] = gnt_i & req_o. All other gnt_o bits are 0.

Handshake:
- Requesters hold all request fields stable from req until gnt.
- If req_o=1 and gnt_i=0: set lock_q=1 and sel_q=sel, so the selection is never switched mid-handshake.
- On grant (req_o & gnt_i):
  - lock_q←0.
  - rr_q←(sel+1) mod NR_PORTS.
  - Push sel into the FIFO if the transaction expects a response (see Configuration).
- A request that is withdrawn while locked is a requester protocol violation. The arbiter clears lock_q when req_i[sel]=0.

Response:
- rvalid_o[head] = rvalid_i & !empty. All other rvalid_o bits are 0.
- On rvalid_i & !empty, pop the FIFO head.
- On rvalid_i & empty: set err_q=1 and drive no rvalid_o.
- rdata_o = rdata_i.

Boundaries:
- FIFO full: req_o forced 0. No grant is possible, even if a pop happens in the same cycle.
- Simultaneous push and pop: count unchanged. The pop applies to the old head.
- rvalid_i in the same cycle as a grant refers to an earlier transaction only.
- Reset mid-operation: FIFO emptied, rr_q=0, lock_q=0, err_q=0. Responses that arrive after reset set err_o.

## Timing
- Reset values:
  - Outputs: gnt_o=0, rvalid_o=0, err_o=0, and req_o=0 unless req_i is asserted after reset.
  - State: rr_q=0, lock_q=0, count=0.
- Request path is combinational: zero-cycle latency from req_i to req_o, and from gnt_i to gnt_o.
- Response path is combinational from rvalid_i to rvalid_o.
- rr_q, lock_q, FIFO and err_q update on the clock edge after the enabling condition.
- Memory must assert rvalid_i at least one cycle after the corresponding gnt_i.
- Responses return strictly in grant order.

## Configuration
- MEM_ARBITER_WRITE_RESP_EN defined:
  - Every granted transaction pushes an ID, writes included.
  - The memory returns one rvalid_i per write.
- MEM_ARBITER_WRITE_RESP_EN undefined:
  - Only reads (we=0) push an ID.
  - Writes complete at grant and never produce rvalid_o.
  - rvalid_i received while only writes are outstanding sets err_o.

## Structure
- Shared package mem_arbiter_pkg holds the function that computes the index width from NR_PORTS and the round-robin next-index function.
- Sub-module mem_arbiter_id_fifo implements the synchronous ID FIFO: push, pop, full, empty, head, and count, with synchronous active-high reset.
- The top level holds the arbitration, lock logic, muxes and error flag.

## Test plan
- Reset, then all req_i=0 → req_o=0, gnt_o=0, rvalid_o=0, err_o=0.
- NR_PORTS=3, all req_i held high, gnt_i=1 every cycle → grants go to port 0,1,2,0,1,2. rvalid_i returned two cycles later → rvalid_o pulses in the same 0,1,2 order.
- Port 1 requesting, gnt_i=0 for 3 cycles, port 0 raises req_i in cycle 1 → selection stays on port 1 until its grant, then port 0 (address_o stable throughout).
- MAX_OUTSTANDING=4, 4 reads granted with no rvalid_i → req_o=0 on the fifth. One rvalid_i → grant resumes on the next cycle.
- rvalid_i pulse with the FIFO empty → err_o=1 and stays 1 until rst_i. rst_i with 2 reads outstanding → count=0.
- Write on port 2: with the macro defined, the ID is pushed and the later rvalid_i routes to rvalid_o[2]. With the macro undefined, no push occurs and the same rvalid_i sets err_o.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared helpers for the memory-port arbiter.
// Holds the port-index width calculation and the round-robin successor.
package mem_arbiter_pkg;

  // Width of a port index; never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 32'd2) ? $clog2(n) : 32'd1;
  endfunction

  // Round-robin successor of cur among n ports, wrapping back to zero.
  function automatic int unsigned rr_next(input int unsigned cur, input int unsigned n);
    return ((cur + 32'd1) >= n) ? 32'd0 : (cur + 32'd1);
  endfunction

endpackage

// File: rtl/mem_arbiter_id_fifo.sv
// mem_arbiter_id_fifo: in-order FIFO of granted port indices.
// Push is ignored when full and pop is ignored when empty; a simultaneous
// push and pop leaves the count unchanged and pops the old head.
module mem_arbiter_id_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 2,
  parameter int unsigned CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] head_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o
);

  localparam int unsigned PW = (DEPTH > 32'd1) ? $clog2(DEPTH) : 32'd1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_q, wr_d;
  logic [PW-1:0]    rd_q, rd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign full_o    = (cnt_q == CW'(DEPTH));
  assign empty_o   = (cnt_q == {CW{1'b0}});
  assign count_o   = cnt_q;
  assign head_o    = mem_q[rd_q];
  assign push_ok_s = push_i & ~full_o;
  assign pop_ok_s  = pop_i & ~empty_o;

  // Next pointers and occupancy from the accepted push/pop pair.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (push_ok_s) begin
      wr_d = (wr_q == PW'(DEPTH - 32'd1)) ? {PW{1'b0}} : (wr_q + PW'(1'b1));
    end else begin
      wr_d = wr_q;
    end
    if (pop_ok_s) begin
      rd_d = (rd_q == PW'(DEPTH - 32'd1)) ? {PW{1'b0}} : (rd_q + PW'(1'b1));
    end else begin
      rd_d = rd_q;
    end
    case ({push_ok_s, pop_ok_s})
      2'b10:   cnt_d = cnt_q + CW'(1'b1);
      2'b01:   cnt_d = cnt_q - CW'(1'b1);
      default: cnt_d = cnt_q;
    endcase
  end

  // Pointer and count registers, cleared by reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_q  <= {PW{1'b0}};
      rd_q  <= {PW{1'b0}};
      cnt_q <= {CW{1'b0}};
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Entry storage; contents are only meaningful while counted as valid.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_q[wr_q] <= data_i;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of one req/gnt/rvalid memory port.
// Requests pass through combinationally; granted port indices are queued
// so in-order responses can be steered back to their owners.
// Build option: MEM_ARBITER_WRITE_RESP_EN -- when defined, writes also
// expect a response and push an ID; otherwise only reads push.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned NR_PORTS        = 3,
  parameter int unsigned ADDRESS_SIZE    = 64,
  parameter int unsigned DATA_WIDTH      = 64,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic [NR_PORTS-1:0]              req_i,
  input  logic [NR_PORTS*ADDRESS_SIZE-1:0] address_i,
  input  logic [NR_PORTS*DATA_WIDTH-1:0]   wdata_i,
  input  logic [NR_PORTS-1:0]              we_i,
  input  logic [NR_PORTS*DATA_WIDTH/8-1:0] be_i,
  output logic [NR_PORTS-1:0]              gnt_o,
  output logic [NR_PORTS-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]            rdata_o,
  output logic                             req_o,
  output logic [ADDRESS_SIZE-1:0]          address_o,
  output logic [DATA_WIDTH-1:0]            wdata_o,
  output logic                             we_o,
  output logic [DATA_WIDTH/8-1:0]          be_o,
  input  logic                             gnt_i,
  input  logic                             rvalid_i,
  input  logic [DATA_WIDTH-1:0]            rdata_i,
  output logic                             err_o
);

  localparam int unsigned IW   = idx_width(NR_PORTS);
  localparam int unsigned CW   = $clog2(MAX_OUTSTANDING + 1);
  localparam int unsigned BE_W = DATA_WIDTH / 8;

  logic [IW-1:0] rr_q, rr_d;
  logic          lock_q, lock_d;
  logic [IW-1:0] sel_q, sel_d;
  logic          err_q, err_d;

  logic [IW-1:0] sel_s;
  logic          found_s;
  logic [IW:0]   raw_s;
  logic [IW:0]   wrap_s;
  logic [IW-1:0] cand_s;
  logic          take_s;
  logic          grant_s;
  logic          push_s;
  logic          pop_s;
  logic          full_s;
  logic          empty_s;
  logic [IW-1:0] head_s;
  logic [CW-1:0] fifo_cnt_s;

  // Selection: hold the locked port, otherwise first requester from rr_q upward.
  always_comb begin
    sel_s   = rr_q;
    found_s = 1'b0;
    raw_s   = {(IW+1){1'b0}};
    wrap_s  = {(IW+1){1'b0}};
    cand_s  = {IW{1'b0}};
    take_s  = 1'b0;
    if (lock_q) begin
      sel_s = sel_q;
    end else begin
      for (int unsigned k = 0; k < NR_PORTS; k++) begin
        raw_s   = {1'b0, rr_q} + (IW+1)'(k);
        wrap_s  = (raw_s >= (IW+1)'(NR_PORTS)) ? (raw_s - (IW+1)'(NR_PORTS)) : raw_s;
        cand_s  = wrap_s[IW-1:0];
        take_s  = ~found_s & req_i[cand_s];
        sel_s   = take_s ? cand_s : sel_s;
        found_s = found_s | take_s;
      end
    end
  end

  // Request fields to memory follow the selected port; full FIFO blocks issue.
  assign req_o     = req_i[sel_s] & ~full_s;
  assign address_o = address_i[sel_s*ADDRESS_SIZE +: ADDRESS_SIZE];
  assign wdata_o   = wdata_i[sel_s*DATA_WIDTH +: DATA_WIDTH];
  assign we_o      = we_i[sel_s];
  assign be_o      = be_i[sel_s*BE_W +: BE_W];
  assign rdata_o   = rdata_i;
  assign err_o     = err_q;

  assign grant_s = req_o & gnt_i;
  assign pop_s   = rvalid_i & ~empty_s;
`ifdef MEM_ARBITER_WRITE_RESP_EN
  assign push_s  = grant_s;
`else
  assign push_s  = grant_s & ~we_o;
`endif

  // One-hot grant and response steering back to the requesters.
  always_comb begin
    gnt_o            = {NR_PORTS{1'b0}};
    rvalid_o         = {NR_PORTS{1'b0}};
    gnt_o[sel_s]     = grant_s;
    rvalid_o[head_s] = pop_s;
  end

  // Next state for pointer, lock and sticky error.
  always_comb begin
    rr_d   = rr_q;
    lock_d = lock_q;
    sel_d  = sel_q;
    if (grant_s) begin
      lock_d = 1'b0;
      rr_d   = IW'(rr_next(32'(sel_s), NR_PORTS));
    end else if (req_o) begin
      lock_d = 1'b1;
      sel_d  = sel_s;
    end else if (lock_q && !req_i[sel_q]) begin
      lock_d = 1'b0;
    end else begin
      lock_d = lock_q;
    end
    err_d = err_q | (rvalid_i & (fifo_cnt_s == {CW{1'b0}}));
  end

  // Arbitration state registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rr_q   <= {IW{1'b0}};
      lock_q <= 1'b0;
      sel_q  <= {IW{1'b0}};
      err_q  <= 1'b0;
    end else begin
      rr_q   <= rr_d;
      lock_q <= lock_d;
      sel_q  <= sel_d;
      err_q  <= err_d;
    end
  end

  mem_arbiter_id_fifo #(
    .DEPTH (MAX_OUTSTANDING),
    .WIDTH (IW),
    .CW    (CW)
  ) u_id_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (push_s),
    .data_i  (sel_s),
    .pop_i   (pop_s),
    .head_o  (head_s),
    .full_o  (full_s),
    .empty_o (empty_s),
    .count_o (fifo_cnt_s)
  );

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic against a
// queue-based reference model of the arbiter.
module tb_mem_arbiter;

  localparam int NP    = 3;
  localparam int AW    = 64;
  localparam int DW    = 64;
  localparam int BW    = DW / 8;
  localparam int DEPTH = 4;
`ifdef MEM_ARBITER_WRITE_RESP_EN
  localparam bit WRESP = 1'b1;
`else
  localparam bit WRESP = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_i;
  logic [NP-1:0]     req_i;
  logic [NP*AW-1:0]  address_i;
  logic [NP*DW-1:0]  wdata_i;
  logic [NP-1:0]     we_i;
  logic [NP*BW-1:0]  be_i;
  logic [NP-1:0]     gnt_o;
  logic [NP-1:0]     rvalid_o;
  logic [DW-1:0]     rdata_o;
  logic              req_o;
  logic [AW-1:0]     address_o;
  logic [DW-1:0]     wdata_o;
  logic              we_o;
  logic [BW-1:0]     be_o;
  logic              gnt_i;
  logic              rvalid_i;
  logic [DW-1:0]     rdata_i;
  logic              err_o;

  always #5 clk = ~clk;

  mem_arbiter #(
    .NR_PORTS(NP), .ADDRESS_SIZE(AW), .DATA_WIDTH(DW), .MAX_OUTSTANDING(DEPTH)
  ) dut (
    .clk_i(clk), .rst_i(rst_i), .req_i(req_i), .address_i(address_i),
    .wdata_i(wdata_i), .we_i(we_i), .be_i(be_i), .gnt_o(gnt_o),
    .rvalid_o(rvalid_o), .rdata_o(rdata_o), .req_o(req_o),
    .address_o(address_o), .wdata_o(wdata_o), .we_o(we_o), .be_o(be_o),
    .gnt_i(gnt_i), .rvalid_i(rvalid_i), .rdata_i(rdata_i), .err_o(err_o)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  // Requester-side view: one pending request per port.
  bit           pend [NP];
  logic [AW-1:0] p_addr [NP];
  logic [DW-1:0] p_wdata [NP];
  bit           p_we [NP];
  logic [BW-1:0] p_be [NP];

  // Reference model state.
  int  rr_m, sel_m;
  bit  lock_m, err_m;
  int  q_m[$];
  int  exp_sel;
  bit  exp_req, exp_grant;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  task automatic pack();
    for (int p = 0; p < NP; p++) begin
      req_i[p]              = pend[p];
      we_i[p]               = p_we[p];
      address_i[p*AW +: AW] = p_addr[p];
      wdata_i[p*DW +: DW]   = p_wdata[p];
      be_i[p*BW +: BW]      = p_be[p];
    end
  endtask

  task automatic set_reqs(input logic [NP-1:0] r);
    for (int p = 0; p < NP; p++) pend[p] = r[p];
    pack();
  endtask

  // Settle combinational outputs, compute expectations and compare.
  task automatic settle();
    int s;
    bit full;
    #3;
    full = (q_m.size() == DEPTH);
    s = -1;
    if (lock_m) s = sel_m;
    else begin
      for (int k = 0; k < NP; k++) begin
        if (s < 0 && req_i[(rr_m + k) % NP]) s = (rr_m + k) % NP;
      end
    end
    exp_sel   = s;
    exp_req   = (s >= 0) && req_i[s] && !full;
    exp_grant = exp_req && gnt_i;
    rdata_i   = {$urandom, $urandom};
    #1;
    check_eq("req_o", {63'd0, req_o}, {63'd0, exp_req});
    check_eq("gnt_o", {61'd0, gnt_o}, exp_grant ? (64'd1 << s) : 64'd0);
    check_eq("rvalid_o", {61'd0, rvalid_o},
             (rvalid_i && q_m.size() > 0) ? (64'd1 << q_m[0]) : 64'd0);
    check_eq("err_o", {63'd0, err_o}, {63'd0, err_m});
    check_eq("rdata_o", rdata_o, rdata_i);
    if (exp_req) begin
      check_eq("address_o", address_o, p_addr[s]);
      check_eq("wdata_o", wdata_o, p_wdata[s]);
      check_eq("we_o", {63'd0, we_o}, {63'd0, p_we[s]});
      check_eq("be_o", {56'd0, be_o}, {56'd0, p_be[s]});
    end
  endtask

  // Clock edge: advance the reference model with the inputs seen there.
  task automatic advance();
    @(posedge clk);
    if (rst_i) begin
      rr_m = 0; lock_m = 0; sel_m = 0; err_m = 0;
      q_m.delete();
    end else begin
      if (rvalid_i) begin
        if (q_m.size() > 0) q_m.delete(0);
        else err_m = 1'b1;
      end
      if (exp_grant) begin
        lock_m = 1'b0;
        rr_m   = (exp_sel + 1) % NP;
        if (!p_we[exp_sel] || WRESP) q_m.push_back(exp_sel);
      end else if (exp_req) begin
        lock_m = 1'b1;
        sel_m  = exp_sel;
      end else if (lock_m && !req_i[sel_m]) begin
        lock_m = 1'b0;
      end
    end
    #1;
  endtask

  task automatic do_reset(input int cycles);
    rst_i = 1'b1; gnt_i = 1'b0; rvalid_i = 1'b0;
    set_reqs('0);
    for (int i = 0; i < cycles; i++) begin
      #4;
      advance();
    end
    rst_i = 1'b0;
  endtask

  task automatic new_ports(input bit all_reads);
    for (int p = 0; p < NP; p++) begin
      p_addr[p]  = {$urandom, $urandom};
      p_wdata[p] = {$urandom, $urandom};
      p_be[p]    = BW'($urandom);
      p_we[p]    = all_reads ? 1'b0 : 1'($urandom_range(0, 1));
    end
  endtask

  initial begin
    rst_i = 1'b1; gnt_i = 1'b0; rvalid_i = 1'b0; rdata_i = '0;
    new_ports(1'b1);
    set_reqs('0);
    #1;
    do_reset(2);

    // Reset state with idle requesters.
    settle();
    check_eq("rst_gnt", {61'd0, gnt_o}, 64'd0);
    advance();

    // Round-robin with everyone requesting and responses two cycles behind.
    for (int k = 0; k < 8; k++) begin
      set_reqs((k < 6) ? 3'b111 : 3'b000);
      gnt_i    = (k < 6);
      rvalid_i = (k >= 2);
      settle();
      if (k < 6) check_eq("rr_gnt", {61'd0, gnt_o}, 64'd1 << (k % 3));
      if (k >= 2) check_eq("rr_rvalid", {61'd0, rvalid_o}, 64'd1 << ((k - 2) % 3));
      advance();
    end
    rvalid_i = 1'b0;

    // Lock holds port 1 while port 0 joins and memory stalls.
    do_reset(1);
    new_ports(1'b1);
    for (int k = 0; k < 7; k++) begin
      case (k)
        0:       set_reqs(3'b010);
        1, 2, 3: set_reqs(3'b011);
        4:       set_reqs(3'b001);
        default: set_reqs(3'b000);
      endcase
      gnt_i    = (k == 3 || k == 4);
      rvalid_i = (k >= 5);
      settle();
      if (k <= 3) check_eq("lock_addr", address_o, p_addr[1]);
      if (k == 3) check_eq("lock_gnt1", {61'd0, gnt_o}, 64'd2);
      if (k == 4) check_eq("lock_gnt0", {61'd0, gnt_o}, 64'd1);
      if (k == 5) check_eq("lock_rv1", {61'd0, rvalid_o}, 64'd2);
      if (k == 6) check_eq("lock_rv0", {61'd0, rvalid_o}, 64'd1);
      advance();
    end
    rvalid_i = 1'b0;

    // FIFO full blocks the fifth read even with a same-cycle pop.
    do_reset(1);
    for (int k = 0; k < 6; k++) begin
      set_reqs(3'b001);
      gnt_i    = 1'b1;
      rvalid_i = (k == 4);
      settle();
      if (k < 4) check_eq("fill_gnt", {61'd0, gnt_o}, 64'd1);
      if (k == 4) begin
        check_eq("full_req", {63'd0, req_o}, 64'd0);
        check_eq("full_rv", {61'd0, rvalid_o}, 64'd1);
      end
      if (k == 5) check_eq("resume_gnt", {61'd0, gnt_o}, 64'd1);
      advance();
    end
    set_reqs('0); gnt_i = 1'b0;
    for (int k = 0; k < 6; k++) begin
      rvalid_i = (k != 5);
      settle();
      advance();
    end
    check_eq("err_sticky0", {63'd0, err_o}, 64'd1);
    rvalid_i = 1'b0;
    for (int k = 0; k < 3; k++) begin
      settle();
      check_eq("err_sticky", {63'd0, err_o}, 64'd1);
      advance();
    end

    // Reset with two reads outstanding empties the FIFO and clears err.
    for (int k = 0; k < 2; k++) begin
      set_reqs(3'b010); gnt_i = 1'b1;
      settle(); advance();
    end
    do_reset(1);
    rvalid_i = 1'b1;
    settle();
    check_eq("rst_err_clr", {63'd0, err_o}, 64'd0);
    check_eq("rst_no_rv", {61'd0, rvalid_o}, 64'd0);
    advance();
    rvalid_i = 1'b0;
    settle();
    check_eq("rst_late_err", {63'd0, err_o}, 64'd1);
    advance();

    // Write on port 2 and its response.
    do_reset(1);
    new_ports(1'b1);
    p_we[2] = 1'b1;
    set_reqs(3'b100); gnt_i = 1'b1;
    settle();
    check_eq("wr_gnt", {61'd0, gnt_o}, 64'd4);
    advance();
    set_reqs('0); gnt_i = 1'b0; rvalid_i = 1'b1;
    settle();
    check_eq("wr_rv", {61'd0, rvalid_o}, WRESP ? 64'd4 : 64'd0);
    advance();
    rvalid_i = 1'b0;
    settle();
    check_eq("wr_err", {63'd0, err_o}, WRESP ? 64'd0 : 64'd1);
    advance();

    // Randomized traffic with protocol-compliant requesters and memory.
    do_reset(1);
    for (int p = 0; p < NP; p++) pend[p] = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      bit was_rst;
      for (int p = 0; p < NP; p++) begin
        if (!pend[p] && $urandom_range(0, 99) < 35) begin
          pend[p]    = 1'b1;
          p_addr[p]  = {$urandom, $urandom};
          p_wdata[p] = {$urandom, $urandom};
          p_be[p]    = BW'($urandom);
          p_we[p]    = 1'($urandom_range(0, 1));
        end
      end
      pack();
      gnt_i    = ($urandom_range(0, 99) < 60);
      rvalid_i = (q_m.size() > 0) && ($urandom_range(0, 99) < 50);
      was_rst  = ($urandom_range(0, 999) < 5);
      rst_i    = was_rst;
      if (was_rst) #4;
      else settle();
      advance();
      if (!was_rst && exp_grant) pend[exp_sel] = 1'b0;
    end
    rst_i = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
